// File: rtl/jtag_dtm_client.sv
// Data-register side of a RISC-V style JTAG debug transport (IDCODE, DTMCS, DMI, BYPASS).
// Supplies capture/shift data to the TAP and issues one outstanding debug-module request.
module jtag_dtm_client #(
    parameter logic [31:0] IDCODE    = 32'h1000_05FB,
    parameter int          ABITS     = 7,
    parameter logic [2:0]  IDLE_HINT = 3'd1
) (
    input  logic             jtag_tck,
    input  logic             jtag_tck__enable,
    input  logic             reset_n,
    input  logic [4:0]       ir,
    input  logic [1:0]       dr_action,
    input  logic [49:0]      dr_in,
    output logic [49:0]      dr_out,
    output logic [49:0]      dr_tdi_mask,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [1:0]       dmi_req_op,
    output logic [ABITS-1:0] dmi_req_address,
    output logic [31:0]      dmi_req_data,
    input  logic             dmi_resp_valid,
    input  logic [31:0]      dmi_resp_data,
    input  logic             dmi_resp_error
);

    localparam int         DMI_LEN     = ABITS + 34;
    localparam logic [4:0] IR_IDCODE   = 5'h01;
    localparam logic [4:0] IR_DTMCS    = 5'h10;
    localparam logic [4:0] IR_DMI      = 5'h11;
    localparam logic [1:0] ACT_CAPTURE = 2'd1;
    localparam logic [1:0] ACT_SHIFT   = 2'd2;
    localparam logic [1:0] ACT_UPDATE  = 2'd3;
    localparam logic [1:0] STAT_OK     = 2'd0;
    localparam logic [1:0] STAT_FAILED = 2'd2;
    localparam logic [1:0] STAT_BUSY   = 2'd3;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WRITE    = 2'd2;
    localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       sticky_r, sticky_s;
    logic [ABITS-1:0] last_addr_r, last_addr_s;
    logic [31:0]      last_data_r, last_data_s;
    logic [1:0]       req_op_r, req_op_s;
    logic [ABITS-1:0] req_addr_r, req_addr_s;
    logic [31:0]      req_data_r, req_data_s;
    logic             req_valid_r;

    logic [49:0] capture_s;
    logic [49:0] mask_s;
    logic [1:0]  cap_op_s;

    logic busy_s, dmi_capture_s, dmi_update_s, dtmcs_update_s;
    logic op_valid_s, hard_reset_s, soft_clear_s, busy_hit_s, resp_done_s;

    assign busy_s         = (state_r != ST_IDLE);
    assign dmi_capture_s  = (ir == IR_DMI) && (dr_action == ACT_CAPTURE);
    assign dmi_update_s   = (ir == IR_DMI) && (dr_action == ACT_UPDATE);
    assign dtmcs_update_s = (ir == IR_DTMCS) && (dr_action == ACT_UPDATE);
    assign op_valid_s     = (dr_in[1:0] == OP_READ) || (dr_in[1:0] == OP_WRITE);
    assign hard_reset_s   = dtmcs_update_s && dr_in[17];
    assign soft_clear_s   = dtmcs_update_s && (dr_in[17] || dr_in[16]);
    // A capture or a new request while busy marks the transport busy; the TAP sees op=3 immediately.
    assign busy_hit_s     = busy_s && (dmi_capture_s || (dmi_update_s && op_valid_s));
    assign resp_done_s    = (state_r == ST_WAIT) && dmi_resp_valid && !hard_reset_s;
    assign cap_op_s       = busy_s ? STAT_BUSY : sticky_r;

    // Request FSM next-state and sticky status
    always_comb begin
        state_s     = state_r;
        last_addr_s = last_addr_r;
        last_data_s = last_data_r;
        req_op_s    = req_op_r;
        req_addr_s  = req_addr_r;
        req_data_s  = req_data_r;
        case (state_r)
            ST_IDLE: begin
                if (dmi_update_s && op_valid_s && (sticky_r == STAT_OK)) begin
                    state_s     = ST_REQ;
                    req_op_s    = dr_in[1:0];
                    req_addr_s  = dr_in[ABITS+33:34];
                    req_data_s  = dr_in[33:2];
                    last_addr_s = dr_in[ABITS+33:34];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (hard_reset_s) begin
                    state_s = ST_IDLE;
                end else if (dmi_req_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (hard_reset_s) begin
                    state_s = ST_IDLE;
                end else if (dmi_resp_valid) begin
                    state_s = ST_IDLE;
                    if (req_op_r == OP_READ) begin
                        last_data_s = dmi_resp_data;
                    end else begin
                        last_data_s = last_data_r;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        if (soft_clear_s) begin
            sticky_s = STAT_OK;
        end else if (busy_hit_s) begin
            sticky_s = STAT_BUSY;
        end else if (resp_done_s && dmi_resp_error && (sticky_r != STAT_BUSY)) begin
            sticky_s = STAT_FAILED;
        end else begin
            sticky_s = sticky_r;
        end
    end

    // State and request registers, advancing only on enabled tck edges
    always_ff @(posedge jtag_tck or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            sticky_r    <= STAT_OK;
            last_addr_r <= '0;
            last_data_r <= 32'd0;
            req_op_r    <= 2'd0;
            req_addr_r  <= '0;
            req_data_r  <= 32'd0;
            req_valid_r <= 1'b0;
        end else if (jtag_tck__enable) begin
            state_r     <= state_s;
            sticky_r    <= sticky_s;
            last_addr_r <= last_addr_s;
            last_data_r <= last_data_s;
            req_op_r    <= req_op_s;
            req_addr_r  <= req_addr_s;
            req_data_r  <= req_data_s;
            req_valid_r <= (state_s == ST_REQ);
        end
    end

    // Per-IR capture value, TDI insertion point and next DR value
    always_comb begin
        capture_s = 50'd0;
        mask_s    = 50'd1;
        case (ir)
            IR_IDCODE: begin
                capture_s = 50'(IDCODE);
                mask_s    = 50'd1 << 6'd31;
            end
            IR_DTMCS: begin
                capture_s = 50'({14'd0, 2'b00, 1'b0, IDLE_HINT, sticky_r, ABITS_FIELD, 4'h1});
                mask_s    = 50'd1 << 6'd31;
            end
            IR_DMI: begin
                capture_s = 50'({last_addr_r, last_data_r, cap_op_s});
                mask_s    = 50'd1 << (DMI_LEN - 1);
            end
            default: begin
                capture_s = 50'd0;
                mask_s    = 50'd1;
            end
        endcase
        case (dr_action)
            ACT_CAPTURE: dr_out = capture_s;
            ACT_SHIFT:   dr_out = dr_in >> 1'd1;
            default:     dr_out = dr_in;
        endcase
    end

    assign dr_tdi_mask     = mask_s;
    assign dmi_req_valid   = req_valid_r;
    assign dmi_req_op      = req_op_r;
    assign dmi_req_address = req_addr_r;
    assign dmi_req_data    = req_data_r;

endmodule

// File: tb/tb_jtag_dtm_client.sv
// Directed bench for jtag_dtm_client: TAP-side actions plus a request scoreboard.
module tb_jtag_dtm_client;

    logic        jtag_tck = 1'b0;
    logic        jtag_tck__enable = 1'b1;
    logic        reset_n = 1'b0;
    logic [4:0]  ir = 5'd0;
    logic [1:0]  dr_action = 2'd0;
    logic [49:0] dr_in = 50'd0;
    logic [49:0] dr_out, dr_tdi_mask;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [1:0]  dmi_req_op;
    logic [6:0]  dmi_req_address;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid = 1'b0;
    logic [31:0] dmi_resp_data = 32'd0;
    logic        dmi_resp_error = 1'b0;

    typedef struct packed {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
    } req_t;

    req_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    jtag_dtm_client dut (
        .jtag_tck(jtag_tck), .jtag_tck__enable(jtag_tck__enable), .reset_n(reset_n),
        .ir(ir), .dr_action(dr_action), .dr_in(dr_in), .dr_out(dr_out), .dr_tdi_mask(dr_tdi_mask),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_op(dmi_req_op),
        .dmi_req_address(dmi_req_address), .dmi_req_data(dmi_req_data),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data), .dmi_resp_error(dmi_resp_error)
    );

    always #5 jtag_tck = ~jtag_tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge jtag_tck);
        #1;
        dr_action = 2'd0;
    endtask

    task automatic drive(input logic [4:0] i, input logic [1:0] a, input logic [49:0] d);
        ir = i;
        dr_action = a;
        dr_in = d;
        #1;
    endtask

    task automatic update(input logic [4:0] i, input logic [49:0] d);
        drive(i, 2'd3, d);
        tick();
    endtask

    function automatic logic [49:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {9'd0, a, d, op};
    endfunction

    task automatic launch(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        req_t e;
        e.op = op;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        update(5'h11, dmi_word(a, d, op));
    endtask

    task automatic wait_req();
        req_t e;
        int n = 0;
        while (!dmi_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", 64'(dmi_req_valid), 64'd1);
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (dmi_req_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("req_op", 64'(dmi_req_op), 64'(e.op));
            check("req_addr", 64'(dmi_req_address), 64'(e.addr));
            check("req_data", 64'(dmi_req_data), 64'(e.data));
        end
    endtask

    task automatic accept();
        dmi_req_ready = 1'b1;
        tick();
        dmi_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic err);
        dmi_resp_valid = 1'b1;
        dmi_resp_data = d;
        dmi_resp_error = err;
        tick();
        dmi_resp_valid = 1'b0;
        dmi_resp_error = 1'b0;
    endtask

    initial begin
        logic [49:0] sr;
        logic [31:0] tdo;

        // Reset values and BYPASS after TAP reset
        #12;
        check("rst_valid", 64'(dmi_req_valid), 64'd0);
        check("rst_op", 64'(dmi_req_op), 64'd0);
        check("rst_addr", 64'(dmi_req_address), 64'd0);
        check("rst_data", 64'(dmi_req_data), 64'd0);
        drive(5'h00, 2'd1, 50'h3_FFFF_FFFF_FFFF);
        check("rst_bypass_cap", 64'(dr_out), 64'd0);
        check("rst_bypass_mask", 64'(dr_tdi_mask), 64'd1);
        reset_n = 1'b1;
        tick();

        // IDCODE capture and 32 shifts
        drive(5'h01, 2'd1, 50'd0);
        check("idcode_mask", 64'(dr_tdi_mask), 64'd1 << 31);
        check("idcode_cap", 64'(dr_out), 64'h1000_05FB);
        sr = dr_out;
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(5'h01, 2'd2, sr);
            tdo[i] = sr[0];
            sr = dr_out;
            tick();
        end
        check("idcode_tdo", 64'(tdo), 64'h1000_05FB);

        drive(5'h10, 2'd1, 50'd0);
        check("dtmcs_cap", 64'(dr_out), 64'h1071);
        check("dtmcs_mask", 64'(dr_tdi_mask), 64'd1 << 31);
        tick();

        // Write with ready delayed two cycles
        drive(5'h11, 2'd0, 50'd0);
        check("dmi_mask", 64'(dr_tdi_mask), 64'd1 << 40);
        launch(2'd2, 7'h10, 32'hCAFE_F00D);
        wait_req();
        tick();
        tick();
        check("req_hold_valid", 64'(dmi_req_valid), 64'd1);
        check("req_hold_addr", 64'(dmi_req_address), 64'h10);
        accept();
        check("wait_valid_low", 64'(dmi_req_valid), 64'd0);
        respond(32'hDEAD_BEEF, 1'b0);
        drive(5'h11, 2'd1, 50'd0);
        check("write_cap", 64'(dr_out), 64'(dmi_word(7'h10, 32'd0, 2'd0)));
        tick();

        // Read with data returned
        launch(2'd1, 7'h11, 32'd0);
        wait_req();
        accept();
        respond(32'h1234_5678, 1'b0);
        drive(5'h11, 2'd1, 50'd0);
        check("read_cap", 64'(dr_out), 64'(dmi_word(7'h11, 32'h1234_5678, 2'd0)));
        tick();

        // Capture while busy
        launch(2'd1, 7'h05, 32'd0);
        wait_req();
        accept();
        drive(5'h11, 2'd1, 50'd0);
        check("busy_cap", 64'(dr_out), 64'(dmi_word(7'h05, 32'h1234_5678, 2'd3)));
        tick();
        respond(32'hAAAA_5555, 1'b0);
        update(5'h11, dmi_word(7'h07, 32'd0, 2'd1));
        tick();
        check("busy_sticky_no_req", 64'(dmi_req_valid), 64'd0);
        drive(5'h10, 2'd1, 50'd0);
        check("dtmcs_busy", 64'(dr_out), 64'h1C71);
        tick();
        update(5'h10, 50'h1_0000);
        drive(5'h11, 2'd1, 50'd0);
        check("dmireset_cap", 64'(dr_out), 64'(dmi_word(7'h05, 32'hAAAA_5555, 2'd0)));
        tick();

        // Response error
        launch(2'd2, 7'h03, 32'h0000_0001);
        wait_req();
        accept();
        respond(32'hFFFF_FFFF, 1'b1);
        drive(5'h10, 2'd1, 50'd0);
        check("dtmcs_failed", 64'(dr_out), 64'h1871);
        tick();
        update(5'h11, dmi_word(7'h04, 32'd9, 2'd2));
        check("failed_no_req", 64'(dmi_req_valid), 64'd0);
        update(5'h10, 50'h1_0000);

        // Hard reset during REQ
        launch(2'd2, 7'h22, 32'h5555_0000);
        wait_req();
        update(5'h10, 50'h2_0000);
        check("hardreset_valid", 64'(dmi_req_valid), 64'd0);
        respond(32'h0BAD_0BAD, 1'b1);
        drive(5'h11, 2'd1, 50'd0);
        check("hardreset_cap", 64'(dr_out), 64'(dmi_word(7'h22, 32'hAAAA_5555, 2'd0)));
        tick();

        // Other IRs decode as BYPASS
        drive(5'h1F, 2'd1, 50'h3_FFFF_FFFF_FFFF);
        check("ir1f_cap", 64'(dr_out), 64'd0);
        check("ir1f_mask", 64'(dr_tdi_mask), 64'd1);
        drive(5'h07, 2'd1, 50'h3_FFFF_FFFF_FFFF);
        check("ir07_cap", 64'(dr_out), 64'd0);
        check("ir07_mask", 64'(dr_tdi_mask), 64'd1);
        tick();

        // Clock enable low: update is not sampled
        jtag_tck__enable = 1'b0;
        drive(5'h11, 2'd3, dmi_word(7'h01, 32'd1, 2'd1));
        @(posedge jtag_tck);
        @(posedge jtag_tck);
        #1;
        check("enable_low", 64'(dmi_req_valid), 64'd0);
        dr_action = 2'd0;
        jtag_tck__enable = 1'b1;
        tick();

        // Asynchronous reset mid-transaction
        launch(2'd1, 7'h30, 32'd0);
        wait_req();
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(dmi_req_valid), 64'd0);
        check("async_rst_op", 64'(dmi_req_op), 64'd0);
        #3;
        reset_n = 1'b1;
        tick();
        check("post_rst_valid", 64'(dmi_req_valid), 64'd0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
